rx_controller: RTL
==================

RX_CONTROLLER -- requirements
Module: rx_controller

Interface
REQ-001 Parameter DATA_BITS, default 8, number of UART data bits per frame, LSB first.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-004 rx  input  1  asynchronous serial line; idle high.
REQ-005 sampling_strobe  input  1  one-cycle pulse at each UART bit midpoint, from the sampling strobe generator.
REQ-006 start_detected  output  1  one-cycle pulse to the strobe generator, marking a start-bit falling edge.
REQ-007 rx_data  output  DATA_BITS  last received byte; stable while rx_data_valid is high.
REQ-008 rx_data_valid  output  1  received byte available; held until it is consumed.
REQ-009 rx_data_ready  input  1  consumer accepts rx_data when rx_data_valid and rx_data_ready are both high.
REQ-010 framing_error  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 overrun_error  output  1  one-cycle pulse when a frame completes while rx_data_valid is still high.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (rx_sync); both flops reset to 1.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-015 IDLE: on a falling edge of rx_sync (previous 1, current 0), pulse start_detected for exactly 1 cycle and go to START.
REQ-016 START: on sampling_strobe, rx_sync == 0 -> DATA with bit_cnt = 0; rx_sync == 1 -> IDLE (false start, no error flag).
REQ-017 DATA: on each sampling_strobe, shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]} and bit_cnt increments.
REQ-018 DATA: on the strobe where bit_cnt == DATA_BITS-1, capture the final bit and go to STOP; bit_cnt width = $clog2(DATA_BITS), no wrap beyond DATA_BITS-1.
REQ-019 STOP, strobe with rx_sync == 1 and rx_data_valid == 0: next cycle rx_data <= shift_reg, rx_data_valid <= 1, and the FSM goes to IDLE.
REQ-020 STOP, strobe with rx_sync == 1 and rx_data_valid == 1: pulse overrun_error next cycle, discard the new byte, leave rx_data unchanged, go to IDLE.
REQ-021 STOP, strobe with rx_sync == 0: pulse framing_error next cycle, discard the byte, go to WAIT_HIGH.
REQ-022 WAIT_HIGH: remain until rx_sync == 1, then go to IDLE; no start detection in this state.
REQ-023 rx_data_valid SHALL clear on the cycle after the handshake (valid & ready).
REQ-024 If the handshake and a new-byte load (REQ-019 conditions) coincide, the new byte SHALL load and valid stays 1.
REQ-025 sampling_strobe SHALL be ignored in IDLE and WAIT_HIGH; a falling edge SHALL be ignored outside IDLE.
REQ-026 start_detected SHALL never be high on two consecutive cycles.
REQ-027 Latency: rx_data_valid rises 1 cycle after the stop-bit strobe; rx line to start_detected is 3 cycles (2 sync flops + edge register).

Reset
REQ-028 While reset_n == 0 at posedge clk, the controller SHALL hold: FSM = IDLE, bit_cnt = 0, shift_reg = 0, rx_data = 0.
REQ-029 While reset_n == 0, all outputs SHALL be 0: rx_data_valid, start_detected, framing_error, overrun_error, busy; both sync flops = 1.
REQ-030 Reset mid-frame SHALL abort the frame with no valid or error pulse, and the FSM SHALL resume in IDLE.

Verification (strobe generator with CLOCKS_PER_BIT = 8; rx_data_ready = 1 unless stated)
REQ-031 Send 0xA5 with a valid stop bit -> exactly 1 start_detected pulse, then rx_data = 0xA5 with rx_data_valid high for 1 cycle, no errors.
REQ-032 Drive a 2-cycle low glitch on idle rx -> start_detected pulses, START returns to IDLE, no valid, busy low afterwards.
REQ-033 Send 0x3C with the stop bit held low for 3 bit times -> framing_error pulses once, no valid, FSM stays in WAIT_HIGH until rx rises, then the next 0x81 is received correctly.
REQ-034 Hold rx_data_ready = 0 and send 0x11 then 0x22 -> rx_data stays 0x11 with valid held high, overrun_error pulses once after the second stop bit.
REQ-035 Assert reset_n = 0 for 1 cycle during data bit 4 of a frame -> all outputs 0, no valid or error pulse, and the next full frame 0x5A is received correctly.
REQ-036 Send back-to-back frames 0xFF, 0x00 with zero idle gap -> both bytes are received in order and start_detected pulses exactly twice.

Source files
------------

// File: rtl/rx_controller.sv
// UART receive FSM: synchronizes rx, frames LSB-first bytes on external midpoint strobes.
// start_detected 3 cycles after rx falls; rx_data_valid 1 cycle after stop strobe, held until valid & ready.
module rx_controller #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 sampling_strobe,
  output logic                 start_detected,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  input  logic                 rx_data_ready,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1, rx_sync, rx_prev;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS:0]   shift_in;
  logic                 start_q, fe_q, oe_q, valid_q;
  logic                 start_d, load_d, fe_d, oe_d;
  logic                 fall, slot_free;

  assign fall      = rx_prev & ~rx_sync;
  assign shift_in  = {rx_sync, shift_q};
  // A byte may land in the output register if it is empty or being drained this cycle.
  assign slot_free = ~valid_q | rx_data_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1   <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      rx_sync <= sync1;
      rx_prev <= rx_sync;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    start_d   = 1'b0;
    load_d    = 1'b0;
    fe_d      = 1'b0;
    oe_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (sampling_strobe) begin
          if (!rx_sync) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (sampling_strobe) begin
          shift_d = shift_in[DATA_BITS:1];
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (sampling_strobe) begin
          if (rx_sync) begin
            if (slot_free) begin
              load_d = 1'b1;
            end else begin
              oe_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_sync) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      fe_q      <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      start_q   <= start_d;
      fe_q      <= fe_d;
      oe_q      <= oe_d;
      if (load_d) begin
        rx_data <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && rx_data_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Outputs are forced low for the whole time reset is held, not just after the first reset edge.
  assign start_detected = reset_n & start_q;
  assign rx_data_valid  = reset_n & valid_q;
  assign framing_error  = reset_n & fe_q;
  assign overrun_error  = reset_n & oe_q;
  assign busy           = reset_n & (state_q != IDLE);

endmodule
